// File: rtl/image_raster_tx.sv
// image_raster_tx
//
// Transmit-side raster streamer for the image encoder pixel port. Pixels are
// accepted from an upstream producer over valid/ready, stamped with their
// raster column/row, and re-issued one cycle later on the encoder's
// valid-only stream. A GAP-cycle idle window follows every emitted pixel so
// the encoder, which cannot apply backpressure, is never over-driven.
//
// Build option: define IMAGE_RASTER_TX_SOF_EN to add in_sof / sof_err
// (start-of-frame realignment with a sticky misalignment flag).
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous reset, active low
//   enable      gate for new accepts; a running gap countdown is not paused
//   in_valid    upstream pixel valid
//   in_ready    pixel accepted this cycle when in_valid is also high
//   in_data     pixel, channel 0 in the LSBs
//   in_sof      (option) accepted pixel starts a new frame at (0,0)
//   sof_err     (option) sticky: in_sof seen away from (0,0)
//   s_valid     one-cycle pulse per emitted pixel
//   s_col/s_row raster position of the emitted pixel
//   s_data      emitted pixel, unmodified
//   frame_done  pulse with the pixel at (WIDTH-1, HEIGHT-1)
//   frame_cnt   completed frames, wraps modulo 2^16
//
// state | meaning
// ------+--------------------------------------------------------
// RUN   | gap_cnt == 0, a pixel may be accepted when enabled
// HOLD  | gap_cnt > 0, counting down the post-pixel idle window
module image_raster_tx #(
    parameter int  WIDTH  = 896,
    parameter int  HEIGHT = 896,
    parameter int  CHANS  = 3,
    parameter int  BITS   = 32,
    parameter int  GAP    = 0,
    localparam int CW     = $clog2(WIDTH) + 1,
    localparam int RW     = $clog2(HEIGHT) + 1,
    localparam int DW     = CHANS * BITS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
`ifdef IMAGE_RASTER_TX_SOF_EN
    input  logic          in_sof,
    output logic          sof_err,
`endif
    output logic          s_valid,
    output logic [CW-1:0] s_col,
    output logic [RW-1:0] s_row,
    output logic [DW-1:0] s_data,
    output logic          frame_done,
    output logic [15:0]   frame_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [7:0]    GAP_LOAD = 8'(GAP);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    state_t        state, state_nxt;
    logic [7:0]    gap_cnt, gap_nxt;
    logic          accept;
    logic [CW-1:0] col, cur_col, col_nxt;
    logic [RW-1:0] row, cur_row, row_nxt;
    logic          col_wrap;
    logic          frame_end;
`ifdef IMAGE_RASTER_TX_SOF_EN
    logic          sof_bad;
`endif

    // in_ready is gated by reset directly so nothing can be taken while the
    // block is held in reset, yet the first edge after release can accept.
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        in_ready  = reset && enable && (gap_cnt == 8'd0);
        accept    = in_valid && in_ready;
        case (state)
            RUN: begin
                if (accept && (GAP_LOAD != 8'd0)) begin
                    gap_nxt   = GAP_LOAD;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                gap_nxt = gap_cnt - 8'd1;
                if (gap_cnt == 8'd1) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            gap_cnt <= 8'd0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    // cur_col/cur_row is the position stamped on the pixel being accepted;
    // a start-of-frame beat overrides it to (0,0) and the raster continues
    // from there, so a truncated frame never reaches its frame_done.
    always_comb begin
        cur_col = col;
        cur_row = row;
`ifdef IMAGE_RASTER_TX_SOF_EN
        sof_bad = 1'b0;
        if (in_sof) begin
            cur_col = '0;
            cur_row = '0;
            sof_bad = (col != '0) || (row != '0);
        end
`endif
        col_wrap  = (cur_col == COL_LAST);
        frame_end = col_wrap && (cur_row == ROW_LAST);
        col_nxt   = col_wrap ? '0 : cur_col + CW'(1);
        row_nxt   = cur_row;
        if (col_wrap) begin
            row_nxt = frame_end ? '0 : cur_row + RW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col        <= '0;
            row        <= '0;
            s_valid    <= 1'b0;
            s_col      <= '0;
            s_row      <= '0;
            s_data     <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= 16'd0;
`ifdef IMAGE_RASTER_TX_SOF_EN
            sof_err    <= 1'b0;
`endif
        end else begin
            s_valid    <= accept;
            frame_done <= accept && frame_end;
            if (accept) begin
                s_col  <= cur_col;
                s_row  <= cur_row;
                s_data <= in_data;
                col    <= col_nxt;
                row    <= row_nxt;
                if (frame_end) begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
`ifdef IMAGE_RASTER_TX_SOF_EN
                if (sof_bad) begin
                    sof_err <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_image_raster_tx.sv
// Bench for image_raster_tx. dut0 (4x2, GAP=0) covers raster order,
// enable gating, mid-frame reset and frame counting; dut2 (4x2, GAP=2)
// covers pacing; dut1 (1x1) makes every pixel a frame so frame_cnt can be
// run all the way round to its wrap.
module tb_image_raster_tx;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int CH   = 3;
    localparam int BT   = 8;
    localparam int DW   = CH * BT;
    localparam int CW   = 3;
    localparam int RW   = 2;
    localparam int GAP2 = 2;

    typedef struct packed {
        logic [CW-1:0] col;
        logic [RW-1:0] row;
        logic [DW-1:0] data;
        logic          fd;
        logic [15:0]   fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          v0, en0, rdy0, sv0, fd0;
    logic [DW-1:0] d0, sd0;
    logic [CW-1:0] col0;
    logic [RW-1:0] row0;
    logic [15:0]   fc0;

    logic          v2, en2, rdy2, sv2, fd2;
    logic [DW-1:0] d2, sd2;
    logic [CW-1:0] col2;
    logic [RW-1:0] row2;
    logic [15:0]   fc2;

    logic          v1, en1, rdy1, sv1, fd1;
    logic [DW-1:0] d1, sd1;
    logic [0:0]    col1, row1;
    logic [15:0]   fc1;

`ifdef IMAGE_RASTER_TX_SOF_EN
    logic sof0, serr0, serr1, serr2, serr_m;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q2[$];
    exp_t e0, e2;
    int   idx0, idx2, gap2;
    logic [15:0] fc0m, fc2m;

    image_raster_tx #(.WIDTH(W), .HEIGHT(H), .CHANS(CH), .BITS(BT), .GAP(0)) dut0 (
        .clk(clk), .reset(rst_n), .enable(en0), .in_valid(v0), .in_ready(rdy0), .in_data(d0),
`ifdef IMAGE_RASTER_TX_SOF_EN
        .in_sof(sof0), .sof_err(serr0),
`endif
        .s_valid(sv0), .s_col(col0), .s_row(row0), .s_data(sd0),
        .frame_done(fd0), .frame_cnt(fc0)
    );

    image_raster_tx #(.WIDTH(W), .HEIGHT(H), .CHANS(CH), .BITS(BT), .GAP(GAP2)) dut2 (
        .clk(clk), .reset(rst_n), .enable(en2), .in_valid(v2), .in_ready(rdy2), .in_data(d2),
`ifdef IMAGE_RASTER_TX_SOF_EN
        .in_sof(1'b0), .sof_err(serr2),
`endif
        .s_valid(sv2), .s_col(col2), .s_row(row2), .s_data(sd2),
        .frame_done(fd2), .frame_cnt(fc2)
    );

    image_raster_tx #(.WIDTH(1), .HEIGHT(1), .CHANS(CH), .BITS(BT), .GAP(0)) dut1 (
        .clk(clk), .reset(rst_n), .enable(en1), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
`ifdef IMAGE_RASTER_TX_SOF_EN
        .in_sof(1'b0), .sof_err(serr1),
`endif
        .s_valid(sv1), .s_col(col1), .s_row(row1), .s_data(sd1),
        .frame_done(fd1), .frame_cnt(fc1)
    );

    // Scoreboard for dut0: every s_valid pops one expected pixel.
    always begin
        @(posedge clk);
        #1;
        checks++;
        if (sv0) begin
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL sb0_extra: s_valid=1 col=%0d row=%0d data=%0d, expected no pixel",
                         col0, row0, sd0);
            end else begin
                e0 = q0.pop_front();
                if (col0 !== e0.col || row0 !== e0.row || sd0 !== e0.data ||
                    fd0 !== e0.fd || fc0 !== e0.fc) begin
                    errors++;
                    $display("FAIL sb0_pixel: got col=%0d row=%0d data=%0d fd=%0b fc=%0d, expected col=%0d row=%0d data=%0d fd=%0b fc=%0d",
                             col0, row0, sd0, fd0, fc0, e0.col, e0.row, e0.data, e0.fd, e0.fc);
                end
            end
        end else if (q0.size() != 0 || fd0 !== 1'b0) begin
            errors++;
            $display("FAIL sb0_missing: s_valid=0 frame_done=%0b, expected %0d pending pixel(s) and frame_done=0",
                     fd0, q0.size());
            q0.delete();
        end
    end

    always begin
        @(posedge clk);
        #1;
        checks++;
        if (sv2) begin
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL sb2_extra: s_valid=1 col=%0d row=%0d data=%0d, expected no pixel",
                         col2, row2, sd2);
            end else begin
                e2 = q2.pop_front();
                if (col2 !== e2.col || row2 !== e2.row || sd2 !== e2.data ||
                    fd2 !== e2.fd || fc2 !== e2.fc) begin
                    errors++;
                    $display("FAIL sb2_pixel: got col=%0d row=%0d data=%0d fd=%0b fc=%0d, expected col=%0d row=%0d data=%0d fd=%0b fc=%0d",
                             col2, row2, sd2, fd2, fc2, e2.col, e2.row, e2.data, e2.fd, e2.fc);
                end
            end
        end else if (q2.size() != 0 || fd2 !== 1'b0) begin
            errors++;
            $display("FAIL sb2_missing: s_valid=0 frame_done=%0b, expected %0d pending pixel(s) and frame_done=0",
                     fd2, q2.size());
            q2.delete();
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic drive0(input logic v, input logic en, input logic [DW-1:0] d, input logic sof);
        exp_t e;
        @(negedge clk);
        v0  = v;
        en0 = en;
        d0  = d;
`ifdef IMAGE_RASTER_TX_SOF_EN
        sof0 = sof;
`endif
        if (v && en && rst_n) begin
            if (sof) begin
`ifdef IMAGE_RASTER_TX_SOF_EN
                if (idx0 != 0) serr_m = 1'b1;
`endif
                idx0 = 0;
            end
            e.col  = CW'(idx0 % W);
            e.row  = RW'(idx0 / W);
            e.data = d;
            e.fd   = (idx0 == W * H - 1);
            if (e.fd) fc0m = fc0m + 16'd1;
            e.fc   = fc0m;
            idx0   = (idx0 + 1) % (W * H);
            q0.push_back(e);
        end
        #1;
    endtask

    task automatic drive2(input logic v, input logic en, input logic [DW-1:0] d, output logic exp_rdy);
        exp_t e;
        @(negedge clk);
        v2  = v;
        en2 = en;
        d2  = d;
        exp_rdy = rst_n && en && (gap2 == 0);
        if (v && exp_rdy) begin
            e.col  = CW'(idx2 % W);
            e.row  = RW'(idx2 / W);
            e.data = d;
            e.fd   = (idx2 == W * H - 1);
            if (e.fd) fc2m = fc2m + 16'd1;
            e.fc   = fc2m;
            idx2   = (idx2 + 1) % (W * H);
            q2.push_back(e);
            gap2   = GAP2;
        end else if (gap2 > 0) begin
            gap2--;
        end
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        v0 = 1'b0;
        v2 = 1'b0;
        idx0 = 0;
        idx2 = 0;
        gap2 = 0;
        fc0m = 16'd0;
        fc2m = 16'd0;
`ifdef IMAGE_RASTER_TX_SOF_EN
        serr_m = 1'b0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        v0 = 1'b1; en0 = 1'b1; d0 = 24'hABCDEF;
        v2 = 1'b1; en2 = 1'b1; d2 = 24'h123456;
        @(posedge clk);
        #1;
        checks++;
        if (rdy0 !== 1'b0 || rdy2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: in_ready dut0=%0b dut2=%0b, expected 0", rdy0, rdy2);
        end
        checks++;
        if (sv0 !== 1'b0 || fd0 !== 1'b0 || fc0 !== 16'd0) begin
            errors++;
            $display("FAIL reset_flags: s_valid=%0b frame_done=%0b frame_cnt=%0d, expected 0", sv0, fd0, fc0);
        end
        checks++;
        if (col0 !== '0 || row0 !== '0 || sd0 !== '0) begin
            errors++;
            $display("FAIL reset_stream: col=%0d row=%0d data=%0d, expected 0", col0, row0, sd0);
        end
`ifdef IMAGE_RASTER_TX_SOF_EN
        checks++;
        if (serr0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_sof_err: sof_err=%0b, expected 0", serr0);
        end
`endif
        v0 = 1'b0;
        v2 = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) begin
            drive0(1'b1, 1'b1, DW'(i), 1'b0);
            @(posedge clk);
            #1;
            checks++;
            if (sv0 !== 1'b1) begin
                errors++;
                $display("FAIL b2b_valid: pixel %0d s_valid=%0b, expected 1", i, sv0);
            end
        end
        drive0(1'b0, 1'b1, '0, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (sv0 !== 1'b0 || fc0 !== 16'd1) begin
            errors++;
            $display("FAIL b2b_frame: s_valid=%0b frame_cnt=%0d, expected 0 and 1", sv0, fc0);
        end
    endtask

    task automatic test_enable_drop();
        for (int i = 1; i <= 3; i++) drive0(1'b1, 1'b1, DW'(i), 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive0(1'b1, 1'b0, DW'(4), 1'b0);
            checks++;
            if (rdy0 !== 1'b0) begin
                errors++;
                $display("FAIL en_ready: disabled cycle %0d in_ready=%0b, expected 0", i, rdy0);
            end
        end
        drive0(1'b1, 1'b1, DW'(4), 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (sv0 !== 1'b1 || col0 !== 3'd3 || row0 !== 2'd0 || sd0 !== DW'(4)) begin
            errors++;
            $display("FAIL en_resume: valid=%0b col=%0d row=%0d data=%0d, expected 1 3 0 4", sv0, col0, row0, sd0);
        end
        for (int i = 5; i <= 8; i++) drive0(1'b1, 1'b1, DW'(i), 1'b0);
        drive0(1'b0, 1'b1, '0, 1'b0);
        checks++;
        if (fc0 !== 16'd2) begin
            errors++;
            $display("FAIL en_frame: frame_cnt=%0d, expected 2", fc0);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 5; i++) drive0(1'b1, 1'b1, DW'(20 + i), 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        v0 = 1'b0;
        idx0 = 0; idx2 = 0; gap2 = 0; fc0m = 16'd0; fc2m = 16'd0;
        @(posedge clk);
        #1;
        checks++;
        if (sv0 !== 1'b0 || col0 !== '0 || row0 !== '0 || sd0 !== '0 ||
            fd0 !== 1'b0 || fc0 !== 16'd0 || rdy0 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: valid=%0b col=%0d row=%0d data=%0d fd=%0b fc=%0d rdy=%0b, expected all 0",
                     sv0, col0, row0, sd0, fd0, fc0, rdy0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive0(1'b1, 1'b1, DW'(9), 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (sv0 !== 1'b1 || col0 !== 3'd0 || row0 !== 2'd0 || sd0 !== DW'(9) || fc0 !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_restart: valid=%0b col=%0d row=%0d data=%0d fc=%0d, expected 1 0 0 9 0",
                     sv0, col0, row0, sd0, fc0);
        end
        drive0(1'b0, 1'b1, '0, 1'b0);
    endtask

    task automatic test_frame_wrap();
        apply_reset();
        for (int i = 0; i < 2 * W * H; i++) drive0(1'b1, 1'b1, DW'(100 + i), 1'b0);
        drive0(1'b0, 1'b1, '0, 1'b0);
        checks++;
        if (fc0 !== 16'd2) begin
            errors++;
            $display("FAIL wrap_two_frames: frame_cnt=%0d, expected 2", fc0);
        end
        // 1x1 instance: one frame per pixel, run to the top of frame_cnt.
        @(negedge clk);
        en1 = 1'b1;
        v1  = 1'b1;
        d1  = 24'h00F00D;
        repeat (65535) @(posedge clk);
        #1;
        checks++;
        if (fc1 !== 16'hFFFF || fd1 !== 1'b1 || col1 !== 1'b0 || row1 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_preload: frame_cnt=%0d fd=%0b col=%0d row=%0d, expected 65535 1 0 0", fc1, fd1, col1, row1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (fc1 !== 16'd0 || fd1 !== 1'b1 || sv1 !== 1'b1 || sd1 !== 24'h00F00D) begin
            errors++;
            $display("FAIL wrap_zero: frame_cnt=%0d fd=%0b valid=%0b data=%0d, expected 0 1 1 %0d",
                     fc1, fd1, sv1, sd1, 24'h00F00D);
        end
        @(negedge clk);
        v1 = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (sv1 !== 1'b0 || fd1 !== 1'b0 || fc1 !== 16'd0 || rdy1 !== 1'b1) begin
            errors++;
            $display("FAIL wrap_idle: valid=%0b fd=%0b fc=%0d rdy=%0b, expected 0 0 0 1", sv1, fd1, fc1, rdy1);
        end
    endtask

    task automatic test_gap();
        logic er;
        int   acc;
        acc = 0;
        for (int c = 0; c < 24; c++) begin
            drive2(1'b1, 1'b1, DW'(acc + 1), er);
            checks++;
            if (rdy2 !== ((c % 3) == 0)) begin
                errors++;
                $display("FAIL gap_ready: cycle %0d in_ready=%0b, expected %0b", c, rdy2, ((c % 3) == 0));
            end
            if (er) acc++;
        end
        drive2(1'b0, 1'b1, '0, er);
        @(posedge clk);
        #1;
        checks++;
        if (fc2 !== 16'd1 || acc != 8) begin
            errors++;
            $display("FAIL gap_frame: frame_cnt=%0d pixels=%0d, expected 1 and 8", fc2, acc);
        end
    endtask

`ifdef IMAGE_RASTER_TX_SOF_EN
    task automatic test_sof();
        apply_reset();
        drive0(1'b1, 1'b1, DW'(1), 1'b0);
        drive0(1'b1, 1'b1, DW'(2), 1'b0);
        drive0(1'b1, 1'b1, DW'(3), 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (col0 !== 3'd0 || row0 !== 2'd0 || serr0 !== 1'b1) begin
            errors++;
            $display("FAIL sof_force: col=%0d row=%0d sof_err=%0b, expected 0 0 1", col0, row0, serr0);
        end
        drive0(1'b1, 1'b1, DW'(4), 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (col0 !== 3'd1 || row0 !== 2'd0 || serr0 !== 1'b1) begin
            errors++;
            $display("FAIL sof_next: col=%0d row=%0d sof_err=%0b, expected 1 0 1", col0, row0, serr0);
        end
        for (int i = 5; i <= 10; i++) drive0(1'b1, 1'b1, DW'(i), 1'b0);
        drive0(1'b0, 1'b1, '0, 1'b0);
        checks++;
        if (serr0 !== serr_m || serr0 !== 1'b1 || serr2 !== 1'b0) begin
            errors++;
            $display("FAIL sof_sticky: sof_err dut0=%0b dut2=%0b, expected 1 and 0", serr0, serr2);
        end
    endtask
`endif

    initial begin
        v0 = 1'b0; en0 = 1'b0; d0 = '0;
        v2 = 1'b0; en2 = 1'b0; d2 = '0;
        v1 = 1'b0; en1 = 1'b0; d1 = '0;
`ifdef IMAGE_RASTER_TX_SOF_EN
        sof0 = 1'b0; serr_m = 1'b0;
`endif
        idx0 = 0; idx2 = 0; gap2 = 0;
        fc0m = 16'd0; fc2m = 16'd0;

        test_reset();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_frame_wrap();
        test_gap();
`ifdef IMAGE_RASTER_TX_SOF_EN
        test_sof();
`endif
        drive0(1'b0, 1'b1, '0, 1'b0);
        @(posedge clk);
        #2;
        checks++;
        if (q0.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL drain: pending dut0=%0d dut2=%0d, expected 0 and 0", q0.size(), q2.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_raster_tx.md
# image_raster_tx

Transmit-side raster streamer that feeds the image encoder's pixel input port. Accepts whole pixels from an upstream producer (DMA/host FIFO) over a valid/ready handshake, stamps each with its raster column and row, and emits the encoder's valid-only stream (`s_valid`, `s_col`, `s_row`, `s_data`) at a programmable issue interval. The encoder applies no backpressure, so this block owns pacing and frame framing.

## Interface
- `WIDTH`, 896: pixels per row.
- `HEIGHT`, 896: rows per frame.
- `CHANS`, 3: channels per pixel.
- `BITS`, 32: bits per channel.
- `GAP`, 0: idle cycles forced after every emitted pixel; range 0..255.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when 0, no new pixel is accepted; any gap countdown in progress continues.
- `in_valid`  in  1  upstream pixel valid.
- `in_ready`  out  1  block accepts the pixel this cycle.
- `in_data`  in  CHANS*BITS  pixel, channel 0 in the LSBs.
- `s_valid`  out  1  one-cycle pulse per emitted pixel.
- `s_col`  out  $clog2(WIDTH)+1  column of emitted pixel.
- `s_row`  out  $clog2(HEIGHT)+1  row of emitted pixel.
- `s_data`  out  CHANS*BITS  emitted pixel, passed through unmodified.
- `frame_done`  out  1  pulse coincident with `s_valid` of pixel (WIDTH-1, HEIGHT-1).
- `frame_cnt`  out  16  completed frames, wraps at 65535 -> 0.

## Operation
- Accept when `in_valid && in_ready`.
- `in_ready = enable && (gap_cnt == 0)`. This is combinational from registered `gap_cnt` and the `enable` input.
- States:
  - RUN: `gap_cnt == 0`.
  - HOLD: `gap_cnt > 0`.
- Transitions:
  - An accept loads `gap_cnt <= GAP`. With GAP=0 the block stays in RUN.
  - HOLD decrements `gap_cnt` each cycle and returns to RUN when it reaches 0.
- Raster counters `col`/`row`:
  - Reset to 0.
  - On accept, the current (`col`, `row`) is registered to `s_col`/`s_row` together with `in_data`.
  - `col` increments on each accept. At WIDTH-1 it wraps to 0 and `row` increments.
  - At (WIDTH-1, HEIGHT-1) both wrap to 0, `frame_done` pulses and `frame_cnt` increments.
- Outputs:
  - `s_col`, `s_row`, `s_data` hold their last values while `s_valid` is 0.
  - `s_valid` is high for exactly one cycle per accepted pixel.
- `enable` falling mid-frame freezes the counters in place. Emission resumes at the same (`col`, `row`) when `enable` returns; no data is lost or duplicated.
- Reset mid-frame: all state returns to reset values and the next accepted pixel is (0,0).
- Arithmetic is unsigned. Counter widths are exactly the port widths, with no saturation.

## Timing
- Latency: a pixel accepted at cycle n appears with `s_valid=1` at cycle n+1.
- Throughput: one pixel per GAP+1 cycles. With GAP=0 that is 1 pixel/cycle sustained.
- `frame_done` and the `frame_cnt` update both occur at cycle n+1 of the last pixel's accept.
- Reset values:
  - `in_ready`=0 while `reset`=0.
  - `s_valid`=0, `s_col`=0, `s_row`=0, `s_data`=0.
  - `frame_done`=0, `frame_cnt`=0, `sof_err`=0.
- First accept is possible on the first rising edge after `reset` deasserts with `enable`=1.

## Configuration
- `IMAGE_RASTER_TX_SOF_EN` defined: adds the input `in_sof` (1 bit, qualifies `in_data`) and the output `sof_err` (1 bit, sticky).
  - An accepted beat with `in_sof=1` forces that pixel to (0,0); the counters continue from (1,0).
  - If `in_sof=1` arrives when the counters are not at (0,0), `sof_err` is set and stays 1 until reset. No `frame_done` is generated for the truncated frame.
  - If `in_sof=0` at counter (0,0), the pixel is still emitted as (0,0) and no error is flagged.
- Macro undefined: ports `in_sof` and `sof_err` are absent and the counters free-run purely on accept count.

## Test plan
- Bench parameters WIDTH=4, HEIGHT=2, GAP=0; stream 8 pixels back-to-back with `in_data`=1..8 -> `s_valid` high for 8 consecutive cycles. `s_col`/`s_row` sequence is (0,0)..(3,0),(0,1)..(3,1). `frame_done` pulses with data 8 and `frame_cnt`=1.
- GAP=2, `in_valid` held 1 -> `in_ready` pattern 1,0,0 repeating and `s_valid` every 3rd cycle. After 8 pixels, 24 cycles have elapsed with `frame_cnt`=1.
- `enable` dropped for 5 cycles after pixel 3 -> no accepts during that window. Pixel 4 is then emitted at (3,0) and the frame completes normally.
- Assert `reset` for 1 cycle after pixel 5 -> all outputs 0 on the next edge. The next pixel is emitted at (0,0) and `frame_cnt`=0.
- Two full frames plus counter preload to 65535 -> `frame_cnt` wraps to 0 on the next `frame_done`.
- `IMAGE_RASTER_TX_SOF_EN`: `in_sof`=1 on pixel 3 -> that pixel is emitted at (0,0), `sof_err`=1 and stays set, and the following pixel is at (1,0).
